// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a private instruction memory,
// dependency/branch stall handling and a branch-resolution wait state.
`default_nettype none

module fetch_unit #(
  parameter int PC_WIDTH   = 16,
  parameter int IR_WIDTH   = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int START_PC   = 0
) (
  input  logic                          I_CLOCK,
  input  logic                          I_RESET,
  input  logic                          I_LOCK,
  input  logic                          I_DepStallSignal,
  input  logic                          I_BranchStallSignal,
  input  logic                          I_BranchAddrSelect,
  input  logic [PC_WIDTH-1:0]           I_BranchPC,
  input  logic                          I_InstWrEn,
  input  logic [$clog2(IMEM_DEPTH)-1:0] I_InstWrAddr,
  input  logic [IR_WIDTH-1:0]           I_InstWrData,
  output logic                          O_LOCK,
  output logic [PC_WIDTH-1:0]           O_PC,
  output logic [IR_WIDTH-1:0]           O_IR,
  output logic                          O_FetchStall
);

  localparam int                AW       = $clog2(IMEM_DEPTH);
  localparam logic [PC_WIDTH-1:0] RESET_PC = START_PC[PC_WIDTH-1:0];
  localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    BR_WAIT = 2'd2
  } state_t;

  state_t             state;
  logic [PC_WIDTH-1:0] pc;
  logic [IR_WIDTH-1:0] mem [IMEM_DEPTH];

  logic [PC_WIDTH-1:0] fetch_addr;
  logic [AW-1:0]       fetch_idx;
  logic [PC_WIDTH-1:0] fetch_next;
  logic                unused_fetch_bits;

  // A fetch in BR_WAIT can only be the redirect, so the address mux keys off state alone.
  always_comb begin
    fetch_addr = (state == BR_WAIT) ? I_BranchPC : pc;
    fetch_idx  = fetch_addr[AW+1:2];
    fetch_next = fetch_addr + PC_STEP;
  end

  // Byte-offset and wrap-around address bits do not select a word.
  assign unused_fetch_bits = ^fetch_addr;

  // Memory deliberately has no reset so a preloaded program survives it.
  always_ff @(negedge I_CLOCK) begin
    if (I_InstWrEn) begin
      mem[I_InstWrAddr] <= I_InstWrData;
    end
  end

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      O_PC         <= '0;
      O_IR         <= '0;
      O_FetchStall <= 1'b1;
      O_LOCK       <= 1'b0;
    end else begin
      O_LOCK <= I_LOCK;
      if (!I_LOCK) begin
        state        <= IDLE;
        O_FetchStall <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            O_IR         <= mem[fetch_idx];
            O_PC         <= fetch_next;
            pc           <= fetch_next;
            O_FetchStall <= 1'b0;
            state        <= RUN;
          end
          RUN: begin
            if (I_DepStallSignal) begin
              O_FetchStall <= 1'b0;
            end else if (I_BranchStallSignal) begin
              O_FetchStall <= 1'b1;
              state        <= BR_WAIT;
            end else begin
              O_IR         <= mem[fetch_idx];
              O_PC         <= fetch_next;
              pc           <= fetch_next;
              O_FetchStall <= 1'b0;
            end
          end
          BR_WAIT: begin
            if (I_BranchAddrSelect) begin
              O_IR         <= mem[fetch_idx];
              O_PC         <= fetch_next;
              pc           <= fetch_next;
              O_FetchStall <= 1'b0;
              state        <= RUN;
            end else begin
              O_FetchStall <= 1'b1;
            end
          end
          default: begin
            state        <= IDLE;
            O_FetchStall <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors for fetch_unit with hand-computed expectations.
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] WA = 32'hAAAA_0001;
  localparam logic [31:0] WB = 32'hBBBB_0002;
  localparam logic [31:0] WC = 32'hCCCC_0003;
  localparam logic [31:0] WD = 32'hDDDD_0004;
  localparam logic [31:0] WE = 32'hEEEE_03FF;
  localparam logic [31:0] WF = 32'hFFFF_0005;
  localparam logic [31:0] WG = 32'h1234_5678;

  logic        clk = 1'b1;
  logic        rst;
  logic        lock;
  logic        dep;
  logic        br;
  logic        sel;
  logic [15:0] br_pc;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        o_lock;
  logic [15:0] o_pc;
  logic [31:0] o_ir;
  logic        o_stall;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit dut (
    .I_CLOCK            (clk),
    .I_RESET            (rst),
    .I_LOCK             (lock),
    .I_DepStallSignal   (dep),
    .I_BranchStallSignal(br),
    .I_BranchAddrSelect (sel),
    .I_BranchPC         (br_pc),
    .I_InstWrEn         (wr_en),
    .I_InstWrAddr       (wr_addr),
    .I_InstWrData       (wr_data),
    .O_LOCK             (o_lock),
    .O_PC               (o_pc),
    .O_IR               (o_ir),
    .O_FetchStall       (o_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] ir,
                            input logic [15:0] pc, input logic stall);
    check({tag, ".ir"}, 64'(o_ir), 64'(ir));
    check({tag, ".pc"}, 64'(o_pc), 64'(pc));
    check({tag, ".stall"}, 64'(o_stall), 64'(stall));
  endtask

  task automatic write_word(input logic [9:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    edge1();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    dep = 1'b0; br = 1'b0; sel = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    lock = 1'b1;
  endtask

  initial begin
    rst = 1'b1; lock = 1'b0; dep = 1'b0; br = 1'b0; sel = 1'b0;
    br_pc = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #1;
    write_word(10'd0, WA);
    write_word(10'd1, WB);
    write_word(10'd2, WC);
    write_word(10'd3, WD);
    write_word(10'd4, WF);
    write_word(10'd1023, WE);

    expect_out("reset", 32'h0, 16'h0, 1'b1);
    check("reset.lock", 64'(o_lock), 64'(0));

    // Straight-line fetch A,B,C,D
    rst = 1'b0; lock = 1'b1;
    edge1(); expect_out("seq0", WA, 16'd4, 1'b0);
    check("seq0.lock", 64'(o_lock), 64'(1));
    edge1(); expect_out("seq1", WB, 16'd8, 1'b0);
    edge1(); expect_out("seq2", WC, 16'd12, 1'b0);
    edge1(); expect_out("seq3", WD, 16'd16, 1'b0);

    // Dependency stall holds B for three edges
    do_reset();
    edge1(); edge1();
    expect_out("dep.pre", WB, 16'd8, 1'b0);
    dep = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge1(); expect_out("dep.hold", WB, 16'd8, 1'b0);
    end
    dep = 1'b0;
    edge1(); expect_out("dep.post", WC, 16'd12, 1'b0);

    // Branch stall, redirect to 0x0C two edges later
    do_reset();
    edge1(); edge1();
    br = 1'b1;
    edge1(); expect_out("br.wait0", WB, 16'd8, 1'b1);
    br = 1'b0; dep = 1'b1;
    edge1(); expect_out("br.wait1", WB, 16'd8, 1'b1);
    dep = 1'b0; sel = 1'b1; br_pc = 16'h000C;
    edge1(); expect_out("br.taken", WD, 16'd16, 1'b0);
    br_pc = 16'h0000;
    edge1(); expect_out("br.selign", WF, 16'd20, 1'b0);
    sel = 1'b0;

    // Dependency wins over branch; then lock drop idles
    do_reset();
    edge1();
    dep = 1'b1; br = 1'b1;
    edge1(); expect_out("both.hold", WA, 16'd4, 1'b0);
    dep = 1'b0; br = 1'b0;
    edge1(); expect_out("both.run", WB, 16'd8, 1'b0);
    lock = 1'b0;
    edge1(); expect_out("unlock", WB, 16'd8, 1'b1);
    check("unlock.lock", 64'(o_lock), 64'(0));
    lock = 1'b1;
    edge1(); expect_out("relock", WC, 16'd12, 1'b0);

    // Asynchronous reset while waiting on a branch
    do_reset();
    edge1(); edge1();
    br = 1'b1;
    edge1(); expect_out("rbr.wait", WB, 16'd8, 1'b1);
    br = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    expect_out("rbr.async", 32'h0, 16'h0, 1'b1);
    check("rbr.lock", 64'(o_lock), 64'(0));
    #1;
    rst = 1'b0; sel = 1'b1; br_pc = 16'h000C;
    edge1(); expect_out("rbr.first", WA, 16'd4, 1'b0);
    sel = 1'b0;

    // Index wrap from the top word, then read-before-write
    do_reset();
    edge1();
    br = 1'b1;
    edge1();
    br = 1'b0; sel = 1'b1; br_pc = 16'h0FFC;
    edge1(); expect_out("wrap.top", WE, 16'h1000, 1'b0);
    sel = 1'b0;
    edge1(); expect_out("wrap.w0", WA, 16'h1004, 1'b0);
    wr_en = 1'b1; wr_addr = 10'd1; wr_data = WG;
    edge1(); expect_out("rbw.old", WB, 16'h1008, 1'b0);
    wr_en = 1'b0;
    br = 1'b1;
    edge1();
    br = 1'b0; sel = 1'b1; br_pc = 16'h0004;
    edge1(); expect_out("rbw.new", WG, 16'h0008, 1'b0);
    sel = 1'b0;

    // PC arithmetic wraps at 2^16
    br = 1'b1;
    edge1();
    br = 1'b0; sel = 1'b1; br_pc = 16'hFFFC;
    edge1(); expect_out("pcwrap", WE, 16'h0000, 1'b0);
    sel = 1'b0;
    edge1(); expect_out("pcwrap.next", WA, 16'h0004, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 16, meaning the program counter width in bits.
REQ-002 SHALL have parameter IR_WIDTH, default 32, meaning the instruction word width in bits.
REQ-003 SHALL have parameter IMEM_DEPTH, default 1024, meaning the number of instruction-memory words (power of 2).
REQ-004 SHALL have parameter START_PC, default 0, meaning the byte address loaded into the PC on reset.
REQ-005 SHALL have port I_CLOCK  in  1  the single clock; all state updates on its falling edge.
REQ-006 SHALL have port I_RESET  in  1  the reset; asynchronous, active-high.
REQ-007 SHALL have port I_LOCK  in  1  pipeline enable.
REQ-008 SHALL have port I_DepStallSignal  in  1  decode data-dependency stall.
REQ-009 SHALL have port I_BranchStallSignal  in  1  decode saw a branch or jump.
REQ-010 SHALL have port I_BranchAddrSelect  in  1  resolved-target valid.
REQ-011 SHALL have port I_BranchPC  in  PC_WIDTH  resolved target byte address.
REQ-012 SHALL have port I_InstWrEn  in  1  instruction-memory load enable.
REQ-013 SHALL have port I_InstWrAddr  in  log2(IMEM_DEPTH)  load word index.
REQ-014 SHALL have port I_InstWrData  in  IR_WIDTH  load data.
REQ-015 SHALL have port O_LOCK  out  1  registered copy of I_LOCK.
REQ-016 SHALL have port O_PC  out  PC_WIDTH  address of the fetched instruction plus 4.
REQ-017 SHALL have port O_IR  out  IR_WIDTH  fetched instruction.
REQ-018 SHALL have port O_FetchStall  out  1  the current O_IR/O_PC is a bubble.

Function
REQ-019 SHALL hold an internal PC (byte address) and instruction-memory word index PC[log2(IMEM_DEPTH)+1:2]; higher bits ignored, so addresses wrap modulo 4*IMEM_DEPTH.
REQ-020 SHALL implement states IDLE, RUN and BR_WAIT.
REQ-021 SHALL register O_LOCK <= I_LOCK on every falling edge.
REQ-022 SHALL, in any state, move to IDLE with PC, O_PC and O_IR held and O_FetchStall <= 1 on a falling edge where I_LOCK=0.
REQ-023 SHALL, in IDLE with I_LOCK=1, perform a normal fetch and enter RUN.
REQ-024 SHALL, for a normal fetch, update O_IR <= mem[PC], O_PC <= PC+4, PC <= PC+4 and O_FetchStall <= 0, giving one-edge latency.
REQ-025 SHALL, in RUN with I_DepStallSignal=1, hold PC, O_PC and O_IR and set O_FetchStall <= 0, so the same instruction is re-presented.
REQ-026 SHALL give I_DepStallSignal priority over I_BranchStallSignal.
REQ-027 SHALL, in RUN with I_BranchStallSignal=1 and I_DepStallSignal=0, hold PC, O_PC and O_IR, set O_FetchStall <= 1 and enter BR_WAIT.
REQ-028 SHALL, in BR_WAIT with I_BranchAddrSelect=0, hold all state and keep O_FetchStall=1, ignoring I_BranchStallSignal and I_DepStallSignal.
REQ-029 SHALL, in BR_WAIT with I_BranchAddrSelect=1, fetch from I_BranchPC on that edge (O_IR <= mem[I_BranchPC], O_PC <= I_BranchPC+4, PC <= I_BranchPC+4, O_FetchStall <= 0) and enter RUN.
REQ-030 SHALL ignore I_BranchAddrSelect outside BR_WAIT.
REQ-031 SHALL wrap PC+4 arithmetic modulo 2^PC_WIDTH.
REQ-032 SHALL write mem[I_InstWrAddr] <= I_InstWrData on a falling edge with I_InstWrEn=1, in any state and independent of I_LOCK.
REQ-033 SHALL, when a fetch and a write hit the same word on the same edge, return the old data (read-before-write).

Reset
REQ-034 SHALL, while I_RESET=1, immediately force state=IDLE, PC=START_PC, O_PC=0, O_IR=0, O_FetchStall=1 and O_LOCK=0.
REQ-035 SHALL abandon a pending BR_WAIT on reset mid-operation.
REQ-036 SHALL NOT clear instruction memory on reset.
REQ-037 SHALL perform its first fetch, from START_PC, on the first falling edge after reset deassertion with I_LOCK=1.

Verification
REQ-038 SHALL cover: load mem[0..3]=A,B,C,D, reset, I_LOCK=1 -> O_IR sequence A,B,C,D with O_PC 4,8,12,16, O_FetchStall=0.
REQ-039 SHALL cover: I_DepStallSignal=1 for 3 edges while O_IR=B -> O_IR=B and O_PC=8 held for 3 edges, then C.
REQ-040 SHALL cover: I_BranchStallSignal=1 at O_IR=B, I_BranchAddrSelect=1 with I_BranchPC=0x0C two edges later -> O_FetchStall=1 for 2 edges, then O_IR=D, O_PC=16, O_FetchStall=0.
REQ-041 SHALL cover: I_DepStallSignal=1 and I_BranchStallSignal=1 together -> held, state RUN, O_FetchStall=0.
REQ-042 SHALL cover: I_RESET asserted in BR_WAIT between clock edges -> outputs reset immediately; after release, fetch from START_PC.
REQ-043 SHALL cover: PC=4*IMEM_DEPTH-4 -> next fetch from word 0; same-address write during a fetch -> old data returned.
